boot_loader: RTL and testbench

Parametrised RAM preload and CPU release sequencer. It sits between an external word stream and the CPU's RAM write port, and replaces the ad-hoc preload muxing done at CPU top level. It accepts a length-prefixed burst over a valid/ready handshake and writes it to consecutive RAM addresses from a base. It optionally verifies a trailing checksum, then holds or releases the controller via `go_contr`.

---
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// RAM preload sequencer: accepts a length-prefixed word burst, writes it from BASE,
// optionally verifies a trailing checksum, then releases the CPU via go_contr.
module boot_loader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AWIDTH = 6,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    input  logic              chk_en,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  ram_addr,
    output logic [WIDTH-1:0]  ram_data,
    output logic              ram_wr,
    output logic              cpu_hold,
    output logic              go_contr,
    output logic              done,
    output logic              err
);

    localparam logic [AWIDTH-1:0] LP_BASE  = AWIDTH'(BASE);
    localparam logic [AWIDTH:0]   LP_DEPTH = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [AWIDTH:0]     r_len;
    logic                r_chk;
    logic [AWIDTH-1:0]   r_addr;
    logic [AWIDTH:0]     r_cnt;
    logic [WIDTH-1:0]    r_sum;
    logic                r_in_ready;
    logic                r_ram_wr;
    logic [AWIDTH-1:0]   r_ram_addr;
    logic [WIDTH-1:0]    r_ram_data;
    logic                r_cpu_hold;
    logic                r_go;
    logic                r_done;
    logic                r_err;

    state_t              w_state_nxt;
    logic [AWIDTH:0]     w_len_nxt;
    logic                w_chk_nxt;
    logic [AWIDTH-1:0]   w_addr_nxt;
    logic [AWIDTH:0]     w_cnt_nxt;
    logic [AWIDTH:0]     w_cnt_inc;
    logic [WIDTH-1:0]    w_sum_nxt;
    logic                w_wr_nxt;
    logic [AWIDTH-1:0]   w_waddr_nxt;
    logic [WIDTH-1:0]    w_wdata_nxt;
    logic                w_hs;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_chk_nxt   = r_chk;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_wr_nxt    = 1'b0;
        w_waddr_nxt = r_ram_addr;
        w_wdata_nxt = r_ram_data;
        w_cnt_inc   = r_cnt + (AWIDTH + 1)'(1);
        w_hs        = in_valid && r_in_ready;

        unique case (r_state)
            // DONE and FAULT share the IDLE start decision so a reload needs no extra cycle
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    w_len_nxt  = len;
                    w_chk_nxt  = chk_en;
                    w_addr_nxt = LP_BASE;
                    w_cnt_nxt  = '0;
                    w_sum_nxt  = '0;
                    if (len == '0)
                        w_state_nxt = chk_en ? S_CHECK : S_RELEASE;
                    else if (len > LP_DEPTH)
                        w_state_nxt = S_FAULT;
                    else
                        w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    w_wr_nxt    = 1'b1;
                    w_waddr_nxt = r_addr;
                    w_wdata_nxt = in_data;
                    w_sum_nxt   = r_sum + in_data;
                    w_cnt_nxt   = w_cnt_inc;
                    w_addr_nxt  = r_addr + AWIDTH'(1);
                    if (w_cnt_inc == r_len)
                        w_state_nxt = r_chk ? S_CHECK : S_RELEASE;
                end
            end
            S_CHECK: begin
                if (w_hs)
                    w_state_nxt = (in_data == r_sum) ? S_RELEASE : S_FAULT;
            end
            S_RELEASE: w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_chk      <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_cpu_hold <= 1'b1;
            r_go       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_chk      <= w_chk_nxt;
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sum      <= w_sum_nxt;
            r_in_ready <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CHECK);
            r_ram_wr   <= w_wr_nxt;
            r_ram_addr <= w_waddr_nxt;
            r_ram_data <= w_wdata_nxt;
            r_cpu_hold <= !((w_state_nxt == S_RELEASE) || (w_state_nxt == S_DONE));
            r_go       <= (w_state_nxt == S_RELEASE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_FAULT);
        end
    end

    assign in_ready = r_in_ready;
    assign ram_wr   = r_ram_wr;
    assign ram_addr = {{(WIDTH - AWIDTH){1'b0}}, r_ram_addr};
    assign ram_data = r_ram_data;
    assign cpu_hold = r_cpu_hold;
    assign go_contr = r_go;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (BASE=0 and BASE=62) share one stimulus and
// are compared every cycle against a transaction-level model of the load sequence.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic        chk_en;
    logic [31:0] in_data;
    logic        in_valid;

    logic        rdy_a, wr_a, hold_a, go_a, done_a, err_a;
    logic [31:0] addr_a, data_a;
    logic        rdy_b, wr_b, hold_b, go_b, done_b, err_b;
    logic [31:0] addr_b, data_b;

    always #5 clk = ~clk;

    boot_loader #(.WIDTH(32), .AWIDTH(6), .BASE(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .len(len), .chk_en(chk_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .ram_addr(addr_a), .ram_data(data_a), .ram_wr(wr_a),
        .cpu_hold(hold_a), .go_contr(go_a), .done(done_a), .err(err_a)
    );

    boot_loader #(.WIDTH(32), .AWIDTH(6), .BASE(62)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .len(len), .chk_en(chk_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .ram_addr(addr_b), .ram_data(data_b), .ram_wr(wr_b),
        .cpu_hold(hold_b), .go_contr(go_b), .done(done_b), .err(err_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wcnt     = 0;
    int gcnt     = 0;

    // Reference model: phase of the load transaction plus running index and sum
    typedef enum {M_IDLE, M_DATA, M_SUM, M_GO, M_DONE, M_FAULT} mphase_t;
    mphase_t     m_ph = M_IDLE;
    int          m_len = 0;
    int          m_idx = 0;
    bit          m_chk = 0;
    logic [31:0] m_sum = '0;

    logic        exp_ready = 0, exp_wr = 0, exp_hold = 1, exp_go = 0, exp_done = 0, exp_err = 0;
    logic [31:0] exp_addr_a = '0, exp_addr_b = '0, exp_data = '0;

    logic [31:0] stream_q[$];

    typedef struct {
        int len;
        bit chk;
        bit good;
        int gap;
        int exp_writes;
        bit exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input bit hs);
        exp_wr = 1'b0;
        if (reset) begin
            m_ph = M_IDLE; m_idx = 0; m_sum = '0;
            exp_addr_a = '0; exp_addr_b = '0; exp_data = '0;
        end else begin
            case (m_ph)
                M_IDLE, M_DONE, M_FAULT: if (start) begin
                    m_len = int'(len); m_chk = chk_en; m_idx = 0; m_sum = '0;
                    if (m_len == 0)      m_ph = chk_en ? M_SUM : M_GO;
                    else if (m_len > 64) m_ph = M_FAULT;
                    else                 m_ph = M_DATA;
                end
                M_DATA: if (hs) begin
                    exp_wr     = 1'b1;
                    exp_addr_a = 32'(m_idx % 64);
                    exp_addr_b = 32'((62 + m_idx) % 64);
                    exp_data   = in_data;
                    m_sum      = m_sum + in_data;
                    m_idx++;
                    if (m_idx == m_len) m_ph = m_chk ? M_SUM : M_GO;
                end
                M_SUM: if (hs) m_ph = (in_data == m_sum) ? M_GO : M_FAULT;
                M_GO:  m_ph = M_DONE;
                default: ;
            endcase
        end
        exp_ready = (m_ph == M_DATA) || (m_ph == M_SUM);
        exp_hold  = !((m_ph == M_GO) || (m_ph == M_DONE));
        exp_go    = (m_ph == M_GO);
        exp_done  = (m_ph == M_DONE);
        exp_err   = (m_ph == M_FAULT);
    endtask

    task automatic compare_all();
        cmp("in_ready_a", rdy_a, exp_ready);   cmp("in_ready_b", rdy_b, exp_ready);
        cmp("ram_wr_a", wr_a, exp_wr);         cmp("ram_wr_b", wr_b, exp_wr);
        cmp("ram_addr_a", addr_a, exp_addr_a); cmp("ram_addr_b", addr_b, exp_addr_b);
        cmp("ram_data_a", data_a, exp_data);   cmp("ram_data_b", data_b, exp_data);
        cmp("cpu_hold_a", hold_a, exp_hold);   cmp("cpu_hold_b", hold_b, exp_hold);
        cmp("go_contr_a", go_a, exp_go);       cmp("go_contr_b", go_b, exp_go);
        cmp("done_a", done_a, exp_done);       cmp("done_b", done_b, exp_done);
        cmp("err_a", err_a, exp_err);          cmp("err_b", err_b, exp_err);
        if (wr_a === 1'b1) wcnt++;
        if (go_a === 1'b1) gcnt++;
    endtask

    task automatic step();
        bit hs;
        @(posedge clk);
        hs = in_valid && exp_ready;
        model_update(hs);
        if (hs && !reset && stream_q.size() > 0) void'(stream_q.pop_front());
        #1;
        compare_all();
        cyc++;
    endtask

    task automatic build_stream(input int n, input bit chk, input bit good);
        logic [31:0] s, w;
        stream_q.delete();
        s = '0;
        if (n <= 64) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                stream_q.push_back(w);
                s = s + w;
            end
            if (chk) stream_q.push_back(good ? s : s + 32'd1);
        end
    endtask

    // gap: 0 back-to-back, 1 valid on alternate cycles, 2 random valid
    task automatic feed(input int gap, input int keep);
        int guard = 0;
        while (stream_q.size() > keep && guard < 1000) begin
            case (gap)
                1:       in_valid = (cyc % 2) == 0;
                2:       in_valid = $urandom_range(0, 1) == 1;
                default: in_valid = 1'b1;
            endcase
            in_data = in_valid ? stream_q[0] : $urandom;
            step();
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input int n, input bit chk, input int gap,
                            input int exp_w, input bit exp_e, input string tag);
        logic [6:0] l;
        l = 7'(n);
        wcnt = 0; gcnt = 0;
        start = 1'b1; len = l; chk_en = chk;
        step();
        start = 1'b0;
        feed(gap, 0);
        repeat (3) step();
        cmp({tag, "_writes"}, 64'(wcnt), 64'(exp_w));
        cmp({tag, "_go_pulses"}, 64'(gcnt), exp_e ? 64'd0 : 64'd1);
        cmp({tag, "_done"}, {63'd0, done_a}, {63'd0, !exp_e});
        cmp({tag, "_err"}, {63'd0, err_a}, {63'd0, exp_e});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; chk_en = 1'b0; in_data = '0; in_valid = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Directed sequences from the load scenarios
        stream_q.delete();
        stream_q.push_back(32'h11); stream_q.push_back(32'h22);
        stream_q.push_back(32'h33); stream_q.push_back(32'h44);
        run_load(4, 0, 0, 4, 0, "basic");

        stream_q.delete();
        stream_q.push_back(32'hFFFF_FFFF); stream_q.push_back(32'h2);
        stream_q.push_back(32'h5); stream_q.push_back(32'h6);
        run_load(3, 1, 0, 3, 0, "csum_pass");

        stream_q.delete();
        stream_q.push_back(32'hFFFF_FFFF); stream_q.push_back(32'h2);
        stream_q.push_back(32'h5); stream_q.push_back(32'h7);
        run_load(3, 1, 0, 3, 1, "csum_fail");

        stream_q.delete();
        run_load(0, 0, 0, 0, 0, "len0_clear_err");

        build_stream(4, 0, 1);
        run_load(4, 0, 1, 4, 0, "wrap_backpressure");

        stream_q.delete();
        run_load(65, 0, 0, 0, 1, "len65");

        build_stream(64, 0, 1);
        run_load(64, 0, 0, 64, 0, "len64");

        // Reset after two of five words, with the stream still offering data
        build_stream(5, 0, 1);
        start = 1'b1; len = 7'd5; chk_en = 1'b0;
        step();
        start = 1'b0;
        feed(0, 3);
        wcnt = 0;
        reset = 1'b1; in_valid = 1'b1; in_data = stream_q[0];
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        step();
        cmp("rst_midload_writes", 64'(wcnt), 64'd0);
        build_stream(5, 0, 1);
        run_load(5, 0, 0, 5, 0, "reload_after_rst");

        // Table of load shapes
        tbl[0] = '{len: 1,   chk: 0, good: 1, gap: 0, exp_writes: 1,  exp_err: 0};
        tbl[1] = '{len: 2,   chk: 1, good: 1, gap: 1, exp_writes: 2,  exp_err: 0};
        tbl[2] = '{len: 5,   chk: 1, good: 0, gap: 2, exp_writes: 5,  exp_err: 1};
        tbl[3] = '{len: 0,   chk: 1, good: 1, gap: 0, exp_writes: 0,  exp_err: 0};
        tbl[4] = '{len: 0,   chk: 1, good: 0, gap: 0, exp_writes: 0,  exp_err: 1};
        tbl[5] = '{len: 64,  chk: 1, good: 1, gap: 2, exp_writes: 64, exp_err: 0};
        tbl[6] = '{len: 127, chk: 0, good: 1, gap: 0, exp_writes: 0,  exp_err: 1};
        tbl[7] = '{len: 63,  chk: 0, good: 1, gap: 1, exp_writes: 63, exp_err: 0};
        for (int i = 0; i < 8; i++) begin
            build_stream(tbl[i].len, tbl[i].chk, tbl[i].good);
            run_load(tbl[i].len, tbl[i].chk, tbl[i].gap, tbl[i].exp_writes, tbl[i].exp_err,
                     $sformatf("tbl%0d", i));
        end

        // Random loads
        for (int i = 0; i < 15; i++) begin
            int  n;
            bit  c, g, e;
            n = int'($urandom_range(0, 70));
            c = $urandom_range(0, 1) == 1;
            g = $urandom_range(0, 3) != 0;
            e = (n > 64) || (c && !g);
            build_stream(n, c, g);
            run_load(n, c, 2, (n > 64) ? 0 : n, e, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
